// File: rtl/sha256_wk_scheduler.sv
// sha256_wk_scheduler: streams SHA-256 schedule words W[t] with round constants K[t] from one 512-bit block.
// Optional SHA256_WK_STALL_EN adds an advance input that gates each step of the stream.
module sha256_wk_scheduler #(
   parameter int WK_LENGTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [511:0]     msg_block,
`ifdef SHA256_WK_STALL_EN
   input  logic             advance,
`endif
   output logic [31:0]      cur_w,
   output logic [31:0]      cur_k,
   output logic [IDX_W-1:0] wk_index,
   output logic             wk_valid,
   output logic             wk_index_complete,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
   state_t           state_q, state_d;
   logic [31:0]      win_q [16];
   logic [31:0]      win_d [16];
   logic [31:0]      cur_k_q, cur_k_d;
   logic [IDX_W-1:0] wk_index_q, wk_index_d;
   logic             adv, load, last, step;
`ifdef SHA256_WK_STALL_EN
   assign adv = advance;
`else
   assign adv = 1'b1;
`endif
   // start is only honoured outside RUN, including on the edge that would finish RUN
   assign load = start && state_q != RUN;
   assign last = wk_index_q == IDX_W'(WK_LENGTH - 1);
   assign step = state_q == RUN && adv && !last;
   always_ff @(posedge clock or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb
      state_d = load ? RUN : (state_q == RUN && adv && last) ? DONE : state_q;
   always_comb begin
      wk_valid          = state_q == RUN;
      busy              = state_q == RUN;
      wk_index_complete = state_q == DONE;
   end
   always_comb begin
      win_d = win_q;
      if (load) begin
         for (int i = 0; i < 16; i++) win_d[i] = msg_block[511 - 32*i -: 32];
      end else if (step) begin
         for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
         win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
      end
   end
   // K is looked up with the next index so it lands in the same edge as the window shift
   always_comb begin
      wk_index_d = load ? '0 : step ? wk_index_q + 1'b1 : wk_index_q;
      cur_k_d    = (load || step) ? K_ROM[wk_index_d] : cur_k_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
         cur_k_q    <= '0;
         wk_index_q <= '0;
      end else begin
         win_q      <= win_d;
         cur_k_q    <= cur_k_d;
         wk_index_q <= wk_index_d;
      end
   assign cur_w    = win_q[0];
   assign cur_k    = cur_k_q;
   assign wk_index = wk_index_q;
endmodule

// File: tb/tb_sha256_wk_scheduler.sv
// tb_sha256_wk_scheduler: directed checks of the W/K stream against a reference schedule.
// Stall scenario is included when SHA256_WK_STALL_EN is defined.
module tb_sha256_wk_scheduler;
   localparam logic [31:0] KREF [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] ONES = {512{1'b1}};
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         advance = 1'b1;
   logic [511:0] msg_block = '0;
   logic [31:0]  cur_w, cur_k;
   logic [5:0]   wk_index;
   logic         wk_valid, wk_index_complete, busy;
   logic [31:0]  wref [64];
   int           checks = 0;
   int           failures = 0;
   sha256_wk_scheduler dut (
      .clock(clock), .reset(reset), .start(start), .msg_block(msg_block),
`ifdef SHA256_WK_STALL_EN
      .advance(advance),
`endif
      .cur_w(cur_w), .cur_k(cur_k), .wk_index(wk_index), .wk_valid(wk_valid),
      .wk_index_complete(wk_index_complete), .busy(busy)
   );
   always #5 clock = ~clock;
   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
   task automatic build_ref(input logic [511:0] m);
      for (int t = 0; t < 16; t++) wref[t] = m[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) wref[t] = s1(wref[t-2]) + wref[t-7] + s0(wref[t-15]) + wref[t-16];
   endtask
   task automatic do_start(input logic [511:0] m);
      start = 1'b1;
      msg_block = m;
      @(posedge clock);
      #1 start = 1'b0;
      msg_block = ~m;
   endtask
   task automatic test_reset;
      @(negedge clock);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== 73'd0) begin
            failures++;
            $display("FAIL reset_idle got w=%h k=%h i=%0d v=%b c=%b b=%b exp all zero", cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy);
         end
      end
      do_start(ABC);
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== 73'd0) begin
         failures++;
         $display("FAIL reset_async got w=%h k=%h i=%0d v=%b c=%b b=%b exp all zero", cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== 73'd0) begin
         failures++;
         $display("FAIL reset_release got w=%h k=%h i=%0d v=%b c=%b b=%b exp all zero", cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy);
      end
   endtask
   task automatic test_abc;
      build_ref(ABC);
      do_start(ABC);
      for (int t = 0; t < 64; t++) begin
         @(negedge clock);
         checks++;
         if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== {wref[t], KREF[t], 6'(t), 3'b101}) begin
            failures++;
            $display("FAIL abc_stream t=%0d got w=%h k=%h i=%0d v=%b c=%b b=%b exp w=%h k=%h", t, cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy, wref[t], KREF[t]);
         end
         if (t == 0 || t == 15 || t == 16 || t == 17) begin
            checks++;
            if (cur_w !== (t == 0 ? 32'h61626380 : t == 15 ? 32'h00000018 : t == 16 ? 32'h61626380 : 32'h000f0000)) begin
               failures++;
               $display("FAIL abc_word t=%0d got w=%h", t, cur_w);
            end
         end
         if (t == 63) begin
            checks++;
            if (cur_k !== 32'hc67178f2) begin
               failures++;
               $display("FAIL abc_k63 got k=%h exp k=c67178f2", cur_k);
            end
         end
      end
      repeat (4) begin
         @(negedge clock);
         checks++;
         if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== {wref[63], KREF[63], 6'd63, 3'b010}) begin
            failures++;
            $display("FAIL abc_done got w=%h k=%h i=%0d v=%b c=%b b=%b exp w=%h k=%h i=63 v=0 c=1 b=0", cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy, wref[63], KREF[63]);
         end
      end
   endtask
   task automatic test_start_during_run;
      build_ref(ABC);
      do_start(ABC);
      for (int t = 0; t < 64; t++) begin
         @(negedge clock);
         checks++;
         if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== {wref[t], KREF[t], 6'(t), 3'b101}) begin
            failures++;
            $display("FAIL run_start_stream t=%0d got w=%h k=%h i=%0d v=%b c=%b exp w=%h k=%h", t, cur_w, cur_k, wk_index, wk_valid, wk_index_complete, wref[t], KREF[t]);
         end
         start = (t == 20 || t == 63);
         msg_block = ONES;
      end
      @(negedge clock);
      start = 1'b0;
      checks++;
      if ({cur_w, wk_index, wk_valid, wk_index_complete, busy} !== {wref[63], 6'd63, 3'b010}) begin
         failures++;
         $display("FAIL run_start_done got w=%h i=%0d v=%b c=%b b=%b exp w=%h i=63 v=0 c=1 b=0", cur_w, wk_index, wk_valid, wk_index_complete, busy, wref[63]);
      end
      @(negedge clock);
      checks++;
      if ({wk_valid, wk_index_complete} !== 2'b01) begin
         failures++;
         $display("FAIL last_edge_start_ignored got v=%b c=%b exp v=0 c=1", wk_valid, wk_index_complete);
      end
   endtask
   task automatic test_back_to_back;
      build_ref(ONES);
      do_start(ONES);
      checks++;
      if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete} !== {32'hffffffff, 32'h428a2f98, 6'd0, 2'b10}) begin
         failures++;
         $display("FAIL b2b_first got w=%h k=%h i=%0d v=%b c=%b exp w=ffffffff k=428a2f98 i=0 v=1 c=0", cur_w, cur_k, wk_index, wk_valid, wk_index_complete);
      end
      for (int t = 0; t < 64; t++) begin
         @(negedge clock);
         checks++;
         if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete} !== {wref[t], KREF[t], 6'(t), 2'b10}) begin
            failures++;
            $display("FAIL b2b_stream t=%0d got w=%h k=%h i=%0d v=%b c=%b exp w=%h k=%h", t, cur_w, cur_k, wk_index, wk_valid, wk_index_complete, wref[t], KREF[t]);
         end
      end
      @(negedge clock);
      checks++;
      if ({wk_valid, wk_index_complete, busy} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_done got v=%b c=%b b=%b exp v=0 c=1 b=0", wk_valid, wk_index_complete, busy);
      end
   endtask
   task automatic test_reset_mid_run;
      build_ref(ABC);
      do_start(ABC);
      repeat (41) @(negedge clock);
      checks++;
      if (wk_index !== 6'd40) begin
         failures++;
         $display("FAIL mid_run_index got i=%0d exp i=40", wk_index);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy} !== 73'd0) begin
         failures++;
         $display("FAIL mid_run_reset got w=%h k=%h i=%0d v=%b c=%b b=%b exp all zero", cur_w, cur_k, wk_index, wk_valid, wk_index_complete, busy);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (30) begin
         @(negedge clock);
         checks++;
         if ({wk_valid, wk_index_complete} !== 2'b00) begin
            failures++;
            $display("FAIL mid_run_no_complete got v=%b c=%b exp v=0 c=0", wk_valid, wk_index_complete);
         end
      end
      do_start(ABC);
      @(negedge clock);
      checks++;
      if ({cur_w, cur_k, wk_index, wk_valid} !== {32'h61626380, 32'h428a2f98, 6'd0, 1'b1}) begin
         failures++;
         $display("FAIL mid_run_restart got w=%h k=%h i=%0d v=%b exp w=61626380 k=428a2f98 i=0 v=1", cur_w, cur_k, wk_index, wk_valid);
      end
      repeat (64) @(negedge clock);
   endtask
`ifdef SHA256_WK_STALL_EN
   task automatic test_stall;
      build_ref(ABC);
      do_start(ABC);
      for (int t = 0; t < 64; t++) begin
         @(negedge clock);
         checks++;
         if ({cur_w, cur_k, wk_index, wk_valid} !== {wref[t], KREF[t], 6'(t), 1'b1}) begin
            failures++;
            $display("FAIL stall_stream t=%0d got w=%h k=%h i=%0d v=%b exp w=%h k=%h", t, cur_w, cur_k, wk_index, wk_valid, wref[t], KREF[t]);
         end
         if (t == 10) begin
            advance = 1'b0;
            repeat (3) begin
               @(negedge clock);
               checks++;
               if ({cur_w, cur_k, wk_index, wk_valid} !== {wref[10], KREF[10], 6'd10, 1'b1}) begin
                  failures++;
                  $display("FAIL stall_hold got w=%h k=%h i=%0d v=%b exp w=%h i=10 v=1", cur_w, cur_k, wk_index, wk_valid, wref[10]);
               end
            end
            advance = 1'b1;
         end
      end
      @(negedge clock);
      checks++;
      if ({wk_valid, wk_index_complete} !== 2'b01) begin
         failures++;
         $display("FAIL stall_done got v=%b c=%b exp v=0 c=1", wk_valid, wk_index_complete);
      end
   endtask
`endif
   initial begin
      test_reset;
      test_abc;
      test_start_during_run;
      test_back_to_back;
      test_reset_mid_run;
`ifdef SHA256_WK_STALL_EN
      test_stall;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sha256_wk_scheduler.md
Name: sha256_wk_scheduler

Overview:
Producer end of the W/K interface feeding the SHA-256 round-update block. It accepts one 512-bit message block and holds it in a 16-word sliding window. It then streams the 64 message-schedule words W[t], with the matching round constant K[t], one pair per cycle. After index 63 it raises a level completion flag, which the round block pipelines internally to trigger its final hash addition.

Parameters:
WK_LENGTH, 64, number of rounds (W/K pairs) streamed per block; only 64 is supported.
IDX_W, 6, width of the round index output.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that loads msg_block and begins streaming; honoured only in IDLE or DONE.
msg_block  input  512  message block. Big-endian word order: W0 = msg_block[511:480], W15 = msg_block[31:0].
cur_w  output  32  current schedule word W[wk_index].
cur_k  output  32  current round constant K[wk_index].
wk_index  output  IDX_W  current round index, 0..63.
wk_valid  output  1  cur_w, cur_k and wk_index are valid this cycle.
wk_index_complete  output  1  level flag: all 64 pairs have been issued; held until the next start or reset.
busy  output  1  high while in RUN.

Behaviour:
- Reset (asynchronous, active-high) forces: state IDLE, window cleared, cur_w=0, cur_k=0, wk_index=0, wk_valid=0, wk_index_complete=0, busy=0.
- All outputs are registered.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: after the cycle presenting index 63 -> DONE.
  - DONE: start -> RUN; otherwise stay in DONE.
- Start latency:
  - start is sampled at edge N.
  - From edge N: wk_valid=1, wk_index=0, cur_w=W0, cur_k=K0.
  - wk_index increments by 1 every cycle, with no gaps, for 64 consecutive cycles.
- Window:
  - 16 x 32-bit shift register win[0..15]; win[0] is W[t].
  - On each RUN advance, win[i] <= win[i+1] for i = 0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], giving W[t+16].
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All sums are modulo 2^32; carries are discarded.
- K constants: 64-entry constant ROM holding the FIPS 180-4 round constants, indexed by the next index value so cur_k is registered alongside cur_w.
- Completion:
  - On the edge after index 63 is presented: wk_valid=0, wk_index_complete=1, busy=0.
  - cur_w, cur_k and wk_index hold their last values (index 63).
  - wk_index never wraps to 0 while valid.
- start while in RUN: ignored; the stream continues unperturbed.
- start in DONE:
  - Clears wk_index_complete on the same edge that presents index 0 of the new block.
  - The flag therefore is never high together with wk_valid.
- start on the same edge that would finish RUN: ignored; the block goes to DONE and a fresh start is required.
- Reset mid-RUN: immediate return to the reset values above; the partial stream is abandoned and wk_index_complete is not asserted.
- msg_block is sampled only on the start edge; later changes have no effect.

Optional Feature:
- Macro: SHA256_WK_STALL_EN.
- Defined:
  - Adds input port advance (1 bit).
  - In RUN, the window, wk_index and cur_k update only on edges where advance=1; otherwise all outputs hold and wk_valid stays 1.
  - Index 0 is presented on the start edge regardless of advance.
  - Completion occurs on the first advance edge after index 63.
  - Reset overrides any stall.
- Not defined: no advance port; the block advances every cycle in RUN exactly as described in Behaviour.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> all outputs 0 immediately, state IDLE; release, no start -> outputs remain 0.
- "abc" block: msg_block = 0x61626380, 14 zero words, 0x00000018; start -> expected outputs:
  - idx0: cur_w=0x61626380, cur_k=0x428a2f98.
  - idx15: cur_w=0x00000018.
  - idx16: cur_w=0x61626380.
  - idx17: cur_w=0x000f0000.
  - idx63: cur_k=0xc67178f2.
  - wk_valid high for exactly 64 cycles, then wk_index_complete=1.
- Start during RUN: pulse start at index 20 with a different msg_block -> stream unchanged through index 63; complete flag asserted as normal.
- Back-to-back blocks: start in DONE with all-ones block -> same edge: wk_index_complete=0, wk_valid=1, idx0 cur_w=0xffffffff.
- Reset mid-RUN: assert reset at index 40 -> outputs zero, wk_index_complete never asserted; a new start yields correct W0/K0.
- SHA256_WK_STALL_EN build: hold advance=0 for 3 cycles at index 10 -> cur_w/wk_index frozen at 10 with wk_valid=1; on resume, index 11 matches the reference W/K sequence.
